vpm_lane_accumulator: RTL and testbench
=======================================

// Module: vpm_lane_accumulator
// PURPOSE
//  Downstream of the variable-precision multiplier: takes its 64-bit packed product word and
//  accumulates it per SIMD lane (1x64, 2x32 or 4x16 slices) into guard-extended accumulators.
//  On end-of-block it drains one lane result per beat over a valid/ready stream.
//  Gives the team multiply-accumulate / dot-product capability in every precision mode.
// PARAMETERS
//  GUARD   8   guard bits added above the 64-bit lane width; accumulator/output width = 64+GUARD
// PORTS
//  clk        in   1         single clock; all state on posedge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         product beat valid
//  in_ready   out  1         block can take a beat
//  in_prod    in   64        multiplier product word
//  in_prec    in   2         {prec1,prec0}: 00=1x32b ops, 01=2x16b, 10=4x8b, 11=reserved
//  in_signed  in   1         SA|SB of the producing multiply; selects sign- vs zero-extension
//  in_last    in   1         final product of the block; triggers drain
//  out_valid  out  1         lane result valid
//  out_ready  in   1         consumer accepts lane result
//  out_data   out  64+GUARD  lane accumulator value
//  out_lane   out  2         lane index of out_data
//  out_last   out  1         high on final lane of the drain
//  out_sat    out  1         lane value was clamped (0 when VPM_ACC_SAT_EN undefined)
//  err_mode   out  1         one-cycle pulse: beat rejected for mode mismatch or prec=11
// BEHAVIOUR
//  - Lanes: mode 00 -> lane0 = prod[63:0]; 01 -> lane k = prod[32k+31:32k], k=0..1;
//    10 -> lane k = prod[16k+15:16k], k=0..3. Slice sign-extended if in_signed else zero-extended
//    to 64+GUARD, then added to acc[k] (wraps modulo 2^(64+GUARD)). Unused lanes untouched.
//  - FSM: IDLE -> ACCUM on first accepted beat (latches mode and signedness);
//    ACCUM -> DRAIN when a beat with in_last is accepted; DRAIN -> IDLE after last lane handshake.
//    A single beat with in_last in IDLE goes straight to DRAIN.
//  - in_ready = 1 in IDLE/ACCUM, 0 in DRAIN. Beat accepted on in_valid & in_ready.
//  - Mode check: in ACCUM a beat whose in_prec or in_signed differs from the latched values, or any
//    beat with in_prec=11, is consumed but not accumulated; err_mode pulses next cycle; an in_last on
//    such a beat still triggers drain. prec=11 beat in IDLE: consumed, no state change.
//  - Latency: in_last accepted at edge t -> out_valid=1, out_lane=0 after edge t (accumulated
//    value includes that last beat). Lanes emitted 0..N-1 (N=1/2/4), one per out handshake;
//    out_data/out_lane/out_last held stable while out_valid & !out_ready.
//  - After final lane handshake: all acc[k] cleared to 0, out_valid drops same edge, in_ready=1.
//  - Reset (any time, incl. mid-drain): acc[*]=0, FSM=IDLE, in_ready=1 after deassertion,
//    out_valid=0, out_data=0, out_lane=0, out_last=0, out_sat=0, err_mode=0; partial data lost.
// CONFIGURATION
//  VPM_ACC_SAT_EN defined: on drain each lane value clamped to native lane width W (16/32/64 for
//   modes 10/01/00): signed -> [-2^(W-1), 2^(W-1)-1], unsigned -> [0, 2^W-1], sign/zero-extended
//   back to 64+GUARD; out_sat=1 for that beat if clamped. Accumulation itself never saturates.
//  Undefined: out_data = raw accumulator; out_sat tied 0.
// TESTING
//  1 prec=10 unsigned, prod=64'h0001_0002_0003_0004 x2 (last on 2nd) -> lanes 0..3 = 8,6,4,2; out_last on lane3
//  2 prec=01 signed, prod=64'hFFFF_FFFF_0000_0005 x3 -> lane0=5*3=15, lane1=-3 (all ones ...FFFD), 2 beats
//  3 prec=00 single beat prod=64'h8000_0000_0000_0000 signed, in_last -> lane0 sign-extended 72'hFF80..00 at t+1
//  4 out_ready held low 5 cycles during drain -> out_data/out_lane stable, in_ready=0, no new beat taken
//  5 prec change 10->01 mid-block -> err_mode pulse, accumulators unchanged; rst_n low mid-drain -> all outputs 0
//  6 SAT_EN: prec=10 unsigned, 16'hFFFF in lane0 x2 -> out_data=16'hFFFF, out_sat=1; without -> 17'h1FFFE, out_sat=0

Source files
------------

// File: rtl/vpm_lane_accumulator.sv
// Per-lane accumulator behind the variable-precision multiplier; drains one lane per beat.
// Optional output clamping to the native lane width when VPM_ACC_SAT_EN is defined.
module vpm_lane_accumulator #(
  parameter int unsigned GUARD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_prod,
  input  logic [1:0]          in_prec,
  input  logic                in_signed,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [64+GUARD-1:0] out_data,
  output logic [1:0]          out_lane,
  output logic                out_last,
  output logic                out_sat,
  output logic                err_mode
);

  localparam int unsigned AW = 64 + GUARD;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q [4];
  logic [AW-1:0] ext [4];
  logic [3:0]    lane_en;
  logic [1:0]    mode_q;
  logic          signed_q;
  logic [1:0]    lane_q;
  logic          err_q;
  logic          take, bad, acc_en, latch_mode, drain_hs, drain_done;
  logic [1:0]    last_lane;
  logic [AW-1:0] raw, sat_data;
  logic          sat_hit;

  always_comb begin
    last_lane  = (mode_q == 2'b10) ? 2'd3 : (mode_q == 2'b01) ? 2'd1 : 2'd0;
    take       = in_valid & in_ready;
    // prec=11 is never accumulated; in ACCUM any change of mode/signedness is rejected too
    bad        = (in_prec == 2'b11) ||
                 ((state_q == StAccum) && ((in_prec != mode_q) || (in_signed != signed_q)));
    acc_en     = take & ~bad;
    latch_mode = take & ~bad & (state_q == StIdle);
    drain_hs   = out_valid & out_ready;
    drain_done = drain_hs & (lane_q == last_lane);
  end

  // Slice and extend the product word into per-lane addends
  always_comb begin
    for (int k = 0; k < 4; k++) ext[k] = '0;
    lane_en = '0;
    case (in_prec)
      2'b00: begin
        ext[0]  = {{GUARD{in_signed & in_prod[63]}}, in_prod};
        lane_en = 4'b0001;
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          ext[k] = {{(AW-32){in_signed & in_prod[32*k+31]}}, in_prod[32*k +: 32]};
        end
        lane_en = 4'b0011;
      end
      2'b10: begin
        for (int k = 0; k < 4; k++) begin
          ext[k] = {{(AW-16){in_signed & in_prod[16*k+15]}}, in_prod[16*k +: 16]};
        end
        lane_en = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take && (in_prec != 2'b11)) state_d = in_last ? StDrain : StAccum;
      StAccum: if (take && in_last) state_d = StDrain;
      StDrain: if (drain_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 2'b00;
      signed_q <= 1'b0;
      lane_q   <= 2'd0;
      err_q    <= 1'b0;
      for (int k = 0; k < 4; k++) acc_q[k] <= '0;
    end else begin
      err_q <= take & bad;
      if (latch_mode) begin
        mode_q   <= in_prec;
        signed_q <= in_signed;
      end
      if (drain_done) begin
        lane_q <= 2'd0;
        for (int k = 0; k < 4; k++) acc_q[k] <= '0;
      end else begin
        if (drain_hs) lane_q <= lane_q + 2'd1;
        if (acc_en) begin
          for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) acc_q[k] <= acc_q[k] + ext[k];
          end
        end
      end
    end
  end

  assign raw = acc_q[lane_q];

`ifdef VPM_ACC_SAT_EN
  logic [AW-1:0] umax, smax, smin;

  always_comb begin
    case (mode_q)
      2'b00:   umax = {{GUARD{1'b0}}, {64{1'b1}}};
      2'b01:   umax = {{(AW-32){1'b0}}, {32{1'b1}}};
      default: umax = {{(AW-16){1'b0}}, {16{1'b1}}};
    endcase
    smax     = umax >> 1;
    smin     = ~smax;
    sat_data = raw;
    sat_hit  = 1'b0;
    if (signed_q) begin
      if ($signed(raw) > $signed(smax)) begin
        sat_data = smax;
        sat_hit  = 1'b1;
      end else if ($signed(raw) < $signed(smin)) begin
        sat_data = smin;
        sat_hit  = 1'b1;
      end
    end else if (raw > umax) begin
      sat_data = umax;
      sat_hit  = 1'b1;
    end
  end
`else
  assign sat_data = raw;
  assign sat_hit  = 1'b0;
`endif

  always_comb begin
    in_ready  = (state_q != StDrain);
    out_valid = (state_q == StDrain);
    out_lane  = lane_q;
    out_last  = out_valid && (lane_q == last_lane);
    out_data  = out_valid ? sat_data : '0;
    out_sat   = out_valid & sat_hit;
    err_mode  = err_q;
  end

endmodule

// File: tb/tb_vpm_lane_accumulator.sv
// Randomized bench for vpm_lane_accumulator against a block-level arithmetic reference model.
// Build with VPM_ACC_SAT_EN defined to check the clamping variant.
module tb_vpm_lane_accumulator;

  localparam int unsigned GUARD = 8;
  localparam int unsigned AW    = 64 + GUARD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_prod = '0;
  logic [1:0]    in_prec = '0;
  logic          in_signed = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_data;
  logic [1:0]    out_lane;
  logic          out_last;
  logic          out_sat;
  logic          err_mode;

  always #5 clk = ~clk;

  vpm_lane_accumulator #(.GUARD(GUARD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_prec   (in_prec),
    .in_signed (in_signed),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .err_mode  (err_mode)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] acc_m [4];
  logic [AW-1:0] exp_d [4];
  logic          exp_s [4];

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nlanes(input logic [1:0] prec);
    return (prec == 2'b00) ? 1 : (prec == 2'b01) ? 2 : 4;
  endfunction

  // Numeric value of lane k as a 72-bit two's-complement quantity
  function automatic logic [AW-1:0] lane_val(input logic [63:0] prod, input logic [1:0] prec,
                                             input logic sgn, input int k);
    int unsigned   w = 64 >> prec;
    logic [AW-1:0] s;
    s = AW'(prod >> (w * k));
    if (w < 64) s = s & ((AW'(1) << w) - AW'(1));
    if (sgn && s[w-1]) s = s - (AW'(1) << w);
    return s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) acc_m[k] = '0;
  endfunction

  function automatic void model_beat(input logic [63:0] prod, input logic [1:0] prec,
                                     input logic sgn);
    for (int k = 0; k < nlanes(prec); k++) acc_m[k] = acc_m[k] + lane_val(prod, prec, sgn, k);
  endfunction

  function automatic void model_finish(input logic [1:0] prec, input logic sgn);
    int unsigned          w = 64 >> prec;
    logic signed [AW-1:0] sv, hi, lo;
    logic [AW-1:0]        umax;
    for (int k = 0; k < 4; k++) begin
      exp_d[k] = acc_m[k];
      exp_s[k] = 1'b0;
`ifdef VPM_ACC_SAT_EN
      sv   = acc_m[k];
      hi   = (AW'(1) << (w - 1)) - AW'(1);
      lo   = -hi - 1;
      umax = (AW'(1) << w) - AW'(1);
      if (sgn) begin
        if (sv > hi) begin exp_d[k] = hi; exp_s[k] = 1'b1; end
        else if (sv < lo) begin exp_d[k] = lo; exp_s[k] = 1'b1; end
      end else if (acc_m[k] > umax) begin
        exp_d[k] = umax;
        exp_s[k] = 1'b1;
      end
`endif
    end
  endfunction

  // Offers one beat at a negedge; it is taken at the following posedge
  task automatic send_beat(input logic [63:0] prod, input logic [1:0] prec, input logic sgn,
                           input logic last, input logic exp_err);
    @(negedge clk);
    check("in_ready", AW'(in_ready), AW'(1));
    in_valid  = 1'b1;
    in_prod   = prod;
    in_prec   = prec;
    in_signed = sgn;
    in_last   = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("err_mode", AW'(err_mode), AW'(exp_err));
  endtask

  // Called at the negedge right after the last beat was taken
  task automatic drain(input int n, input logic rand_ready);
    int            got = 0;
    int            budget = 0;
    logic          stalled = 1'b0;
    logic [AW-1:0] held_d = '0;
    logic [1:0]    held_l = '0;
    check("drain_valid", AW'(out_valid), AW'(1));
    check("drain_lane0", AW'(out_lane), AW'(0));
    while (got < n && budget < 300) begin
      out_ready = rand_ready ? ($urandom_range(2, 0) != 0) : 1'b1;
      if (stalled) begin
        check("hold_data", out_data, held_d);
        check("hold_lane", AW'(out_lane), AW'(held_l));
      end
      check("drain_in_ready", AW'(in_ready), AW'(0));
      if (out_valid && out_ready) begin
        check("out_data", out_data, exp_d[got]);
        check("out_lane", AW'(out_lane), AW'(got));
        check("out_last", AW'(out_last), AW'(got == n - 1));
        check("out_sat", AW'(out_sat), AW'(exp_s[got]));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        held_d  = out_data;
        held_l  = out_lane;
      end
      @(negedge clk);
      budget++;
    end
    out_ready = 1'b0;
    if (got < n) check("drain_timeout", AW'(got), AW'(n));
    check("idle_valid", AW'(out_valid), AW'(0));
    check("idle_ready", AW'(in_ready), AW'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, AW'(out_valid), AW'(0));
    check({tag, "_data"}, out_data, AW'(0));
    check({tag, "_lane"}, AW'(out_lane), AW'(0));
    check({tag, "_last"}, AW'(out_last), AW'(0));
    check({tag, "_sat"}, AW'(out_sat), AW'(0));
    check({tag, "_err"}, AW'(err_mode), AW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] prod;
    logic [1:0]  prec, bprec;
    logic        sgn, bsgn, bad, last;
    int          nb;

    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", AW'(in_ready), AW'(1));

    // Test 1: 4x16 unsigned, two equal beats
    model_clear();
    send_beat(64'h0001_0002_0003_0004, 2'b10, 1'b0, 1'b0, 1'b0);
    send_beat(64'h0001_0002_0003_0004, 2'b10, 1'b0, 1'b1, 1'b0);
    exp_d[0] = AW'(8); exp_d[1] = AW'(6); exp_d[2] = AW'(4); exp_d[3] = AW'(2);
    for (int k = 0; k < 4; k++) exp_s[k] = 1'b0;
    drain(4, 1'b1);

    // Test 2: 2x32 signed, three beats
    for (int b = 0; b < 3; b++) send_beat(64'hFFFF_FFFF_0000_0005, 2'b01, 1'b1, b == 2, 1'b0);
    exp_d[0] = AW'(15);
    exp_d[1] = {AW{1'b1}} - AW'(2);
    drain(2, 1'b0);

    // Test 3: single-beat block straight from idle
    send_beat(64'h8000_0000_0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    exp_d[0] = {8'hFF, 64'h8000_0000_0000_0000};
    drain(1, 1'b1);

    // Reserved precision in idle: rejected, no state change
    send_beat(64'h1234, 2'b11, 1'b0, 1'b1, 1'b1);
    check("p11_valid", AW'(out_valid), AW'(0));
    check("p11_ready", AW'(in_ready), AW'(1));

    // Test 5a: mode change mid-block is dropped, drain still follows
    model_clear();
    send_beat(64'h0010_0020_0030_0040, 2'b10, 1'b0, 1'b0, 1'b0);
    model_beat(64'h0010_0020_0030_0040, 2'b10, 1'b0);
    send_beat(64'h1111_1111_1111_1111, 2'b01, 1'b0, 1'b0, 1'b1);
    send_beat(64'h2222_2222_2222_2222, 2'b10, 1'b1, 1'b0, 1'b1);
    send_beat(64'h0001_0001_0001_0001, 2'b10, 1'b0, 1'b1, 1'b0);
    model_beat(64'h0001_0001_0001_0001, 2'b10, 1'b0);
    model_finish(2'b10, 1'b0);
    drain(4, 1'b1);

    // Test 4: consumer stalls five cycles while a beat is offered
    model_clear();
    send_beat(64'h0000_0007_0000_0009, 2'b01, 1'b0, 1'b1, 1'b0);
    model_beat(64'h0000_0007_0000_0009, 2'b01, 1'b0);
    model_finish(2'b01, 1'b0);
    prod = out_data;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_prod   = 64'hDEAD_BEEF_DEAD_BEEF;
      in_prec   = 2'b01;
      check("stall_in_ready", AW'(in_ready), AW'(0));
      check("stall_data", out_data, exp_d[0]);
      check("stall_lane", AW'(out_lane), AW'(0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain(2, 1'b0);

    // Test 6: unsigned 16-bit overflow into the guard bits
    model_clear();
    send_beat(64'h0000_0000_0000_FFFF, 2'b10, 1'b0, 1'b0, 1'b0);
    send_beat(64'h0000_0000_0000_FFFF, 2'b10, 1'b0, 1'b1, 1'b0);
`ifdef VPM_ACC_SAT_EN
    exp_d[0] = AW'(17'h0FFFF); exp_s[0] = 1'b1;
`else
    exp_d[0] = AW'(17'h1FFFE); exp_s[0] = 1'b0;
`endif
    for (int k = 1; k < 4; k++) begin exp_d[k] = '0; exp_s[k] = 1'b0; end
    drain(4, 1'b1);

    // Test 5b: reset in the middle of a drain
    send_beat(64'h0005_0005_0005_0005, 2'b10, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", AW'(in_ready), AW'(1));
    model_clear();
    send_beat(64'h0003_0002_0001_0000, 2'b10, 1'b0, 1'b1, 1'b0);
    model_beat(64'h0003_0002_0001_0000, 2'b10, 1'b0);
    model_finish(2'b10, 1'b0);
    drain(4, 1'b1);

    // Randomized blocks with occasional rejected beats
    for (int blk = 0; blk < 40; blk++) begin
      prec = 2'($urandom_range(2, 0));
      sgn  = 1'($urandom_range(1, 0));
      nb   = $urandom_range(5, 1);
      model_clear();
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(3, 0))
          0:       prod = 64'hFFFF_FFFF_FFFF_FFFF;
          1:       prod = 64'h7FFF_7FFF_7FFF_7FFF;
          default: prod = {$urandom, $urandom};
        endcase
        last = (b == nb - 1);
        bad  = (b > 0) && ($urandom_range(4, 0) == 0);
        if (bad) begin
          bprec = prec;
          bsgn  = sgn;
          case ($urandom_range(2, 0))
            0:       bprec = (prec == 2'b10) ? 2'b00 : prec + 2'b01;
            1:       bsgn  = ~sgn;
            default: bprec = 2'b11;
          endcase
          send_beat(prod, bprec, bsgn, last, 1'b1);
        end else begin
          send_beat(prod, prec, sgn, last, 1'b0);
          model_beat(prod, prec, sgn);
        end
      end
      model_finish(prec, sgn);
      drain(nlanes(prec), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
